// File: rtl/vsram_wait.sv
// vsram_wait: wait-stated single-port word SRAM with byte enables and ready/ack handshake.
// Define VSRAM_CLEAR_EN to zero the whole array after every reset release.
`timescale 1ns/1ps
module vsram_wait #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int WAIT_CYC = 2,
    localparam int BE_W = DATA_W / 8,
    localparam int CMD_W = 1 + DATA_W + BE_W + ADDR_W
) (
    input  logic              sck,
    input  logic              rst,
    input  logic              cs_n,
    input  logic [CMD_W-1:0]  mosi,
    output logic [DATA_W-1:0] miso,
    output logic              ready,
    output logic              ack
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC == 0 ? 0 : WAIT_CYC - 1);
`ifdef VSRAM_CLEAR_EN
    typedef enum logic [1:0] {IDLE, WAIT, DONE, CLEAR} state_t;
    logic [ADDR_W-1:0] clr_addr;
`else
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
`endif
    state_t            state;
    logic [3:0]        cnt;
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              do_acc;
    logic [CMD_W-1:0]  acc_cmd;
    logic              acc_we;
    logic [DATA_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic [ADDR_W-1:0] acc_addr;
    // With no wait states the access runs straight off mosi on the acceptance edge
    always_comb begin
        accept    = !cs_n && ready;
        acc_cmd   = (state == WAIT) ? cmd : mosi;
        do_acc    = (WAIT_CYC == 0) ? accept : (state == WAIT && cnt == 4'd0);
        acc_we    = acc_cmd[CMD_W-1];
        acc_wdata = acc_cmd[CMD_W-2 -: DATA_W];
        acc_be    = acc_cmd[ADDR_W +: BE_W];
        acc_addr  = acc_cmd[ADDR_W-1:0];
    end
    always_ff @(posedge sck) begin
        for (int i = 0; i < BE_W; i++)
            if (do_acc && acc_we && acc_be[i]) mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
`ifdef VSRAM_CLEAR_EN
        if (state == CLEAR) mem[clr_addr] <= '0;
`endif
    end
    always_ff @(posedge sck or negedge rst) begin
        if (!rst) begin
`ifdef VSRAM_CLEAR_EN
            state    <= CLEAR;
            ready    <= 1'b0;
            clr_addr <= '0;
`else
            state    <= IDLE;
            ready    <= 1'b1;
`endif
            ack      <= 1'b0;
            miso     <= '0;
            cnt      <= '0;
            cmd      <= '0;
        end else begin
            ack <= 1'b0;
            if (do_acc && !acc_we) miso <= mem[acc_addr];
            case (state)
                IDLE, DONE: begin
                    state <= (accept && WAIT_CYC != 0) ? WAIT : IDLE;
                    ready <= !(accept && WAIT_CYC != 0);
                    ack   <= accept && WAIT_CYC == 0;
                    if (accept) begin
                        cmd <= mosi;
                        cnt <= CNT_INIT;
                    end
                end
                WAIT: begin
                    state <= (cnt == 4'd0) ? DONE : WAIT;
                    ready <= (cnt == 4'd0);
                    ack   <= (cnt == 4'd0);
                    cnt   <= cnt - 4'd1;
                end
`ifdef VSRAM_CLEAR_EN
                CLEAR: begin
                    state    <= (clr_addr == '1) ? IDLE : CLEAR;
                    ready    <= (clr_addr == '1);
                    clr_addr <= clr_addr + 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vsram_wait.sv
// tb_vsram_wait: transaction-level model check of vsram_wait at WAIT_CYC=0 and WAIT_CYC=2.
`timescale 1ns/1ps
module tb_vsram_wait;
`ifdef VSRAM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif
    logic        sck = 1'b0;
    logic        rst;
    logic [1:0]  cs;
    logic [24:0] mo [2];
    logic [15:0] ms [2];
    logic [1:0]  rdy, ak;
    int checks = 0;
    int failures = 0;

    always #5 sck = ~sck;

    vsram_wait #(.WAIT_CYC(0)) dut0 (.sck(sck), .rst(rst), .cs_n(cs[0]), .mosi(mo[0]),
                                     .miso(ms[0]), .ready(rdy[0]), .ack(ak[0]));
    vsram_wait #(.WAIT_CYC(2)) dut1 (.sck(sck), .rst(rst), .cs_n(cs[1]), .mosi(mo[1]),
                                     .miso(ms[1]), .ready(rdy[1]), .ack(ak[1]));

    // Model: a command accepted at edge E0 performs its access at edge E0+W.
    logic [15:0] mm [2][64];
    logic [24:0] pcmd [2];
    bit          pend [2];
    int          left [2];
    int          clr [2];
    logic        e_ready [2];
    logic        e_ack [2];
    logic [15:0] e_miso [2];

    always @(posedge sck or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                pend[k] = 0;
                e_ack[k] = 1'b0;
                e_miso[k] = '0;
                clr[k] = CLR ? 64 : 0;
                e_ready[k] = (clr[k] == 0);
            end else begin
                e_ack[k] = 1'b0;
                if (clr[k] > 0) begin
                    mm[k][64-clr[k]] = '0;
                    clr[k]--;
                end else begin
                    if (!cs[k] && e_ready[k]) begin
                        pcmd[k] = mo[k];
                        pend[k] = 1;
                        left[k] = (k == 0) ? 0 : 2;
                    end else if (pend[k]) left[k]--;
                    if (pend[k] && left[k] == 0) begin
                        if (pcmd[k][24]) begin
                            if (pcmd[k][6]) mm[k][pcmd[k][5:0]][7:0]  = pcmd[k][15:8];
                            if (pcmd[k][7]) mm[k][pcmd[k][5:0]][15:8] = pcmd[k][23:16];
                        end else e_miso[k] = mm[k][pcmd[k][5:0]];
                        pend[k] = 0;
                        e_ack[k] = 1'b1;
                    end
                end
                e_ready[k] = (clr[k] == 0) && !pend[k];
            end
        end
    end

    always @(negedge sck) begin
        for (int k = 0; k < 2; k++) begin
            checks += 3;
            if (rdy[k] !== e_ready[k]) begin
                failures++;
                $display("FAIL model_ready[%0d] t=%0t got=%b exp=%b", k, $time, rdy[k], e_ready[k]);
            end
            if (ak[k] !== e_ack[k]) begin
                failures++;
                $display("FAIL model_ack[%0d] t=%0t got=%b exp=%b", k, $time, ak[k], e_ack[k]);
            end
            if (ms[k] !== e_miso[k]) begin
                failures++;
                $display("FAIL model_miso[%0d] t=%0t got=%h exp=%h", k, $time, ms[k], e_miso[k]);
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge sck);
        #1;
    endtask

    task automatic wait_ready;
        for (int i = 0; i < 200 && !rdy[1]; i++) @(negedge sck);
        chk("wait_ready", 32'(rdy[1]), 1);
        tick();
    endtask

    task automatic xfer(input logic we, input logic [15:0] wd, input logic [1:0] be, input logic [5:0] a,
                        output int lat, output int low, output logic [15:0] rd);
        cs[1] = 1'b0;
        mo[1] = {we, wd, be, a};
        tick();
        cs[1] = 1'b1;
        lat = 0;
        low = 0;
        rd = 'x;
        for (int i = 1; i <= 20; i++) begin
            @(negedge sck);
            if (!rdy[1]) low++;
            if (ak[1]) begin
                lat = i;
                rd = ms[1];
                break;
            end
        end
        if (lat == 0) chk("ack_timeout", 0, 1);
        tick();
    endtask

    int lat, low, acks, n;
    logic [15:0] rd;

    initial begin
        rst = 1'b0;
        cs = 2'b11;
        mo[0] = '0;
        mo[1] = '0;
        repeat (2) tick();
        @(negedge sck);
        chk("rst_ready", 32'(rdy[1]), CLR ? 0 : 1);
        chk("rst_ack", 32'(ak[1]), 0);
        chk("rst_miso", 32'(ms[1]), 0);
        tick();
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sck);
            if (rdy[1]) break;
            n++;
        end
        chk("clear_len", 32'(n), CLR ? 64 : 0);
        tick();
        if (CLR) begin
            xfer(0, 0, 0, 0, lat, low, rd);
            chk("clear_rd0", 32'(rd), 0);
            xfer(0, 0, 0, 63, lat, low, rd);
            chk("clear_rd63", 32'(rd), 0);
        end
        xfer(1, 16'hBEEF, 2'b11, 5, lat, low, rd);
        chk("wr_lat", 32'(lat), 3);
        chk("wr_low", 32'(low), 2);
        xfer(0, 16'h0000, 2'b00, 5, lat, low, rd);
        chk("rd_lat", 32'(lat), 3);
        chk("rd_beef", 32'(rd), 32'hBEEF);
        xfer(1, 16'h1234, 2'b11, 9, lat, low, rd);
        xfer(1, 16'hABCD, 2'b01, 9, lat, low, rd);
        xfer(0, 16'h0000, 2'b00, 9, lat, low, rd);
        chk("be_lane0", 32'(rd), 32'h12CD);
        xfer(1, 16'hFFFF, 2'b00, 9, lat, low, rd);
        chk("be_none_ack", 32'(lat), 3);
        chk("be_none_miso", 32'(rd), 32'h12CD);
        xfer(0, 16'h0000, 2'b00, 9, lat, low, rd);
        chk("be_none_mem", 32'(rd), 32'h12CD);
        mo[1] = {1'b1, 16'hFFFF, 2'b11, 6'd9};
        acks = 0;
        repeat (4) begin
            @(negedge sck);
            acks += 32'(ak[1]);
        end
        chk("cs_high_ack", 32'(acks), 0);
        tick();
        cs[1] = 1'b0;
        mo[1] = {1'b1, 16'h1111, 2'b11, 6'd20};
        tick();
        mo[1] = {1'b1, 16'hFFFF, 2'b11, 6'd9};
        tick();
        cs[1] = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge sck);
            acks += 32'(ak[1]);
        end
        chk("busy_ignored_ack", 32'(acks), 1);
        tick();
        xfer(0, 16'h0000, 2'b00, 9, lat, low, rd);
        chk("busy_ignored_mem", 32'(rd), 32'h12CD);
        xfer(0, 16'h0000, 2'b00, 20, lat, low, rd);
        chk("first_cmd_mem", 32'(rd), 32'h1111);
        xfer(1, 16'h5555, 2'b11, 3, lat, low, rd);
        cs[1] = 1'b0;
        mo[1] = {1'b1, 16'h9999, 2'b11, 6'd3};
        tick();
        cs[1] = 1'b1;
        rst = 1'b0;
        @(negedge sck);
        chk("midrst_ready", 32'(rdy[1]), CLR ? 0 : 1);
        chk("midrst_ack", 32'(ak[1]), 0);
        chk("midrst_miso", 32'(ms[1]), 0);
        tick();
        rst = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge sck);
            acks += 32'(ak[1]);
        end
        chk("midrst_no_ack", 32'(acks), 0);
        wait_ready();
        xfer(0, 16'h0000, 2'b00, 3, lat, low, rd);
        chk("midrst_mem", 32'(rd), CLR ? 0 : 32'h5555);
        cs[0] = 1'b0;
        mo[0] = {1'b1, 16'h0001, 2'b11, 6'd0};
        @(posedge sck);
        #1;
        mo[0] = {1'b0, 16'h0000, 2'b00, 6'd0};
        @(negedge sck);
        chk("w0_wr_ack", 32'(ak[0]), 1);
        chk("w0_ready", 32'(rdy[0]), 1);
        @(posedge sck);
        #1;
        cs[0] = 1'b1;
        @(negedge sck);
        chk("w0_rd_ack", 32'(ak[0]), 1);
        chk("w0_rd_miso", 32'(ms[0]), 1);
        @(negedge sck);
        chk("w0_ack_end", 32'(ak[0]), 0);
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vsram_wait.md
Name: vsram_wait

Overview:
- Parametrised successor to the team's virtual SRAM: single-port word memory behind the same packed-command `mosi`/`miso` style interface.
- Adds configurable width and depth, byte-write enables and a programmable wait-state count.
- Adds a ready/ack handshake and registered read data, so software-visible timing matches a real slow SRAM.
- Sits between the core's load/store unit and the data-memory address space.

Parameters:
- DATA_W, 16: data word width; must be a multiple of 8.
- ADDR_W, 6: word address width; DEPTH = 2**ADDR_W words.
- WAIT_CYC, 2: wait states inserted per access, 0..15.
- Derived (localparam) BE_W = DATA_W/8.
- Derived (localparam) CMD_W = 1 + DATA_W + BE_W + ADDR_W.

Ports:
- sck  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- cs_n  input  1  chip select, active-low; a command is presented only while cs_n=0.
- mosi  input  CMD_W  command word, packed MSB to LSB as {we, wdata[DATA_W-1:0], be[BE_W-1:0], addr[ADDR_W-1:0]}.
- miso  output  DATA_W  registered read data; holds its value until the next read completes.
- ready  output  1  block can accept a command this cycle.
- ack  output  1  one-cycle pulse when a command completes (read or write).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ready=1, ack=0, miso=0, wait counter=0, captured command cleared. Memory contents are not reset.
- Acceptance: on a rising sck with cs_n=0 and ready=1, mosi is captured. With cs_n=1, or with ready=0, mosi is ignored; nothing is queued, and the master must hold the command.
- FSM states: IDLE, WAIT, DONE.
- IDLE, WAIT_CYC=0: the access executes on the acceptance edge; the state stays IDLE, ready stays 1, and ack=1 for the following cycle. Back-to-back commands complete one per cycle.
- IDLE, WAIT_CYC>0: accept, go to WAIT, ready=0, counter loaded with WAIT_CYC-1.
- WAIT: decrement the counter each edge. On the edge where counter==0, execute the access and go to DONE.
- DONE: lasts one cycle, with ack=1 and ready=1. A new command may be accepted in DONE, and the FSM handles it exactly as from IDLE. Otherwise DONE returns to IDLE.
- Timing with wait states: acceptance edge E0, access edge E(WAIT_CYC); ack is high in the cycle after E(WAIT_CYC). Issue-to-issue spacing is WAIT_CYC+1 cycles.
- Write access (we=1): for each byte lane i with be[i]=1, mem[addr][8i+7:8i] <= wdata lane i. Lanes with be=0 are unchanged. be=0 on all lanes gives no memory change but still ack; miso unchanged.
- Read access (we=0): miso <= mem[addr] on the access edge; wdata and be are ignored. A read in the cycle after a write to the same address returns the new data.
- All addresses are in range; no wrap or error condition.
- Reset mid-WAIT: the pending command is dropped; no memory write and no ack.
- ack and ready are never both low in IDLE.

Optional Feature:
- VSRAM_CLEAR_EN defined: after rst deasserts, the FSM enters CLEAR and writes 0 to addresses 0..DEPTH-1, one per cycle, ascending. ready=0 throughout CLEAR (reset value of ready becomes 0). ready rises in the cycle after the write to DEPTH-1 (DEPTH cycles after reset release). No ack is issued for the clear. Reset during CLEAR restarts it from address 0.
- Not defined: no CLEAR state; ready=1 out of reset; memory power-up contents are undefined (X in simulation).

Test Plan:
- Defaults, write we=1, addr=5, wdata=16'hBEEF, be=2'b11: ready low 2 cycles, ack high in cycle 3. Then read addr=5: miso=16'hBEEF with ack, same latency.
- Byte enable: write 16'h1234 to addr 9, then write 16'hABCD with be=2'b01 -> read addr 9 returns 16'h12CD.
- Back-to-back at WAIT_CYC=0: write 16'h0001 to addr 0 then immediately read addr 0 -> ack every cycle, miso=16'h0001 one cycle after the read issue.
- Commands ignored: cs_n=1 with a valid write, and a second command driven while ready=0 -> memory unchanged, no extra ack.
- rst pulsed low during WAIT of a write to addr 3 (previously 16'h5555) -> ack never pulses, ready=1, miso=0, read addr 3 returns 16'h5555.
- VSRAM_CLEAR_EN, ADDR_W=6: release reset -> ready low exactly 64 cycles; reads of addr 0 and 63 return 0.
